pic16f84_hex_loader: RTL and testbench

Streaming Intel HEX record parser and program-memory writer for the PIC16F84 model. It accepts ASCII characters one per handshake and decodes `:LLAAAATT<data>CC` records. It verifies each record's checksum and only then issues 14-bit word writes into program memory. It is the write-side counterpart of the instruction ROM, filling the same word-addressed store that the ROM serves to the fetch path.

---
 rtl/pic16f84_hex_loader_pkg.sv | 57 +++++
 rtl/pic16f84_hex_loader_if.sv | 34 +++
 rtl/pic16f84_hex_loader_recbuf.sv | 35 +++
 rtl/pic16f84_hex_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pic16f84_hex_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pic16f84_hex_loader_pkg.sv
// pic16f84_hex_pkg
// Shared definitions for the Intel HEX program-memory loader:
//   - state encoding of the record parser
//   - record type (TT) codes
//   - error codes reported on err_code_out
//   - ASCII framing characters
//   - hex_decode: ASCII hex digit -> {valid, nibble}
package pic16f84_hex_pkg;

  typedef logic [3:0] state_t;

  // Parser states; everything up to ST_CSUM is a character-accepting state,
  // which the top relies on when deriving ch_ready_out.
  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_COUNT = 4'd1;
  localparam state_t ST_ADDR  = 4'd2;
  localparam state_t ST_TYPE  = 4'd3;
  localparam state_t ST_DATA  = 4'd4;
  localparam state_t ST_CSUM  = 4'd5;
  localparam state_t ST_CHECK = 4'd6;
  localparam state_t ST_WRITE = 4'd7;
  localparam state_t ST_DONE  = 4'd8;
  localparam state_t ST_ERR   = 4'd9;

  localparam logic [7:0] TT_DATA = 8'h00;
  localparam logic [7:0] TT_EOF  = 8'h01;
  localparam logic [7:0] TT_ESA  = 8'h02;
  localparam logic [7:0] TT_SSA  = 8'h03;
  localparam logic [7:0] TT_ELA  = 8'h04;
  localparam logic [7:0] TT_SLA  = 8'h05;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BADCHAR = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TYPE    = 3'd4;
  localparam logic [2:0] ERR_ALIGN   = 3'd5;
  localparam logic [2:0] ERR_RANGE   = 3'd6;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Returns {valid, value}. Letters map through the low ASCII nibble:
  // 'A'/'a' have low nibble 1, so adding 9 yields 10.
  function automatic logic [4:0] hex_decode(input logic [7:0] ch);
    logic [3:0] low;
    low = ch[3:0] + 4'd9;
    if (ch >= 8'h30 && ch <= 8'h39)
      hex_decode = {1'b1, ch[3:0]};
    else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
      hex_decode = {1'b1, low};
    else
      hex_decode = 5'd0;
  endfunction

endpackage

// File: rtl/pic16f84_hex_loader_if.sv
// pic16f84_hex_loader_if
// Bundles the character stream, program-memory write port and status of the
// HEX loader.
//   master: character source / memory side (drives clr_in, ch_valid_in, ch_in)
//   slave : the loader (drives ready, write strobe/address/data and status)
interface pic16f84_hex_loader_if
  import pic16f84_hex_pkg::*;
#(
  parameter int ADDR_W = 14
);
  logic              clr_in;
  logic              ch_valid_in;
  logic [7:0]        ch_in;
  logic              ch_ready_out;
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [13:0]       wr_data_out;
  logic              busy_out;
  logic              done_out;
  logic              err_out;
  logic [2:0]        err_code_out;

  modport master (
    output clr_in, ch_valid_in, ch_in,
    input  ch_ready_out, wr_en_out, wr_addr_out, wr_data_out,
           busy_out, done_out, err_out, err_code_out
  );

  modport slave (
    input  clr_in, ch_valid_in, ch_in,
    output ch_ready_out, wr_en_out, wr_addr_out, wr_data_out,
           busy_out, done_out, err_out, err_code_out
  );
endinterface

// File: rtl/pic16f84_hex_loader_recbuf.sv
// pic16f84_hex_recbuf
// Record data buffer, MAX_DATA bytes.
//   clk       : clock
//   byte_we   : store byte_data at byte_idx on the rising edge
//   byte_idx  : byte position within the record
//   byte_data : data byte
//   word_idx  : word number i, reads bytes 2*i (lo) and 2*i+1 (hi)
//   word_lo   : byte 2*i
//   word_hi   : byte 2*i+1
module pic16f84_hex_recbuf
  import pic16f84_hex_pkg::*;
#(
  parameter int MAX_DATA = 16,
  parameter int BIDX_W   = 4,
  parameter int WIDX_W   = 3
)(
  input  logic              clk,
  input  logic              byte_we,
  input  logic [BIDX_W-1:0] byte_idx,
  input  logic [7:0]        byte_data,
  input  logic [WIDX_W-1:0] word_idx,
  output logic [7:0]        word_lo,
  output logic [7:0]        word_hi
);
  logic [7:0] mem [MAX_DATA];

  // Plain storage; contents are only read for bytes the current record wrote.
  always_ff @(posedge clk) begin
    if (byte_we)
      mem[byte_idx] <= byte_data;
  end

  assign word_lo = mem[{word_idx, 1'b0}];
  assign word_hi = mem[{word_idx, 1'b1}];
endmodule

// File: rtl/pic16f84_hex_loader.sv
// pic16f84_hex_loader
// Streaming Intel HEX parser that checksums each :LLAAAATT<data>CC record and
// only then writes its 14-bit words into PIC16F84 program memory.
//   clk_in   : clock, rising edge
//   rst_n_in : synchronous active-low reset
//   bus      : pic16f84_hex_loader_if.slave
//              clr_in re-arm, ch_valid_in/ch_in/ch_ready_out character
//              handshake, wr_en_out/wr_addr_out/wr_data_out word writes,
//              busy_out/done_out/err_out/err_code_out status
module pic16f84_hex_loader
  import pic16f84_hex_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int MAX_DATA = 16
)(
  input logic                  clk_in,
  input logic                  rst_n_in,
  pic16f84_hex_loader_if.slave bus
);
  localparam int BIDX_W = (MAX_DATA > 2) ? $clog2(MAX_DATA) : 1;
  localparam int WIDX_W = (BIDX_W > 1) ? BIDX_W - 1 : 1;

  state_t            state, state_nxt;
  logic [1:0]        nib_cnt, nib_cnt_nxt;
  logic [3:0]        nib_hi, nib_hi_nxt;
  logic [7:0]        ll, ll_nxt;
  logic [15:0]       addr, addr_nxt;
  logic [7:0]        tt, tt_nxt;
  logic [7:0]        sum, sum_nxt;
  logic [7:0]        data_cnt, data_cnt_nxt;
  logic [7:0]        wr_idx, wr_idx_nxt;

  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [13:0]       wr_data_nxt;
  logic              done_nxt, err_nxt;
  logic [2:0]        err_code_nxt;

  logic              accept;
  logic              nib_ok;
  logic [3:0]        nib_val;
  logic [7:0]        cur_byte;
  logic              buf_we;
  logic [7:0]        lo_byte, hi_byte;
  logic [16:0]       last_word;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_hi_bits;

  assign accept         = bus.ch_valid_in && bus.ch_ready_out;
  assign {nib_ok, nib_val} = hex_decode(bus.ch_in);
  assign cur_byte       = {nib_hi, nib_val};
  assign buf_we         = accept && nib_ok && (state == ST_DATA) && nib_cnt[0] && !bus.clr_in;
  // Word address of the last word the record would write; anything set at or
  // above bit ADDR_W means the record runs off the end of program memory.
  assign last_word      = {2'b00, addr[15:1]} + {10'd0, ll[7:1]} - 17'd1;
  assign word_addr      = ADDR_W'(addr[15:1]) + ADDR_W'(wr_idx);
  // Upper two bits of the high byte are not part of a 14-bit instruction.
  assign unused_hi_bits = ^hi_byte[7:6];

  pic16f84_hex_recbuf #(
    .MAX_DATA(MAX_DATA),
    .BIDX_W  (BIDX_W),
    .WIDX_W  (WIDX_W)
  ) u_recbuf (
    .clk      (clk_in),
    .byte_we  (buf_we),
    .byte_idx (data_cnt[BIDX_W-1:0]),
    .byte_data(cur_byte),
    .word_idx (wr_idx[WIDX_W-1:0]),
    .word_lo  (lo_byte),
    .word_hi  (hi_byte)
  );

  // Next-state logic: each accepted character either completes a nibble,
  // a byte, or a field. Bytes are assembled from nib_hi plus the current
  // nibble, so the checksum accumulates on every second nibble.
  always_comb begin
    state_nxt    = state;
    nib_cnt_nxt  = nib_cnt;
    nib_hi_nxt   = nib_hi;
    ll_nxt       = ll;
    addr_nxt     = addr;
    tt_nxt       = tt;
    sum_nxt      = sum;
    data_cnt_nxt = data_cnt;
    wr_idx_nxt   = wr_idx;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = bus.wr_addr_out;
    wr_data_nxt  = bus.wr_data_out;
    done_nxt     = bus.done_out;
    err_nxt      = bus.err_out;
    err_code_nxt = bus.err_code_out;

    if (bus.clr_in) begin
      state_nxt    = ST_IDLE;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      err_code_nxt = ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && bus.ch_in == ASCII_COLON) begin
            state_nxt    = ST_COUNT;
            nib_cnt_nxt  = 2'd0;
            ll_nxt       = 8'd0;
            addr_nxt     = 16'd0;
            tt_nxt       = 8'd0;
            sum_nxt      = 8'd0;
            data_cnt_nxt = 8'd0;
            wr_idx_nxt   = 8'd0;
          end
        end

        ST_COUNT, ST_ADDR, ST_TYPE, ST_DATA, ST_CSUM: begin
          if (accept) begin
            if (!nib_ok) begin
              state_nxt    = ST_ERR;
              err_nxt      = 1'b1;
              err_code_nxt = ERR_BADCHAR;
            end else if (state == ST_ADDR) begin
              addr_nxt    = {addr[11:0], nib_val};
              nib_cnt_nxt = nib_cnt + 2'd1;
              if (nib_cnt[0])
                sum_nxt = sum + {addr[3:0], nib_val};
              if (nib_cnt == 2'd3)
                state_nxt = ST_TYPE;
            end else if (!nib_cnt[0]) begin
              nib_hi_nxt  = nib_val;
              nib_cnt_nxt = 2'd1;
            end else begin
              nib_cnt_nxt = 2'd0;
              sum_nxt     = sum + cur_byte;
              case (state)
                ST_COUNT: begin
                  ll_nxt = cur_byte;
                  if (cur_byte > 8'(MAX_DATA)) begin
                    state_nxt    = ST_ERR;
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_LEN;
                  end else begin
                    state_nxt = ST_ADDR;
                  end
                end
                ST_TYPE: begin
                  tt_nxt = cur_byte;
                  if (cur_byte > TT_SLA) begin
                    state_nxt    = ST_ERR;
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_TYPE;
                  end else if (cur_byte == TT_DATA && ll[0]) begin
                    state_nxt    = ST_ERR;
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_LEN;
                  end else if (ll == 8'd0) begin
                    state_nxt = ST_CSUM;
                  end else begin
                    state_nxt = ST_DATA;
                  end
                end
                ST_DATA: begin
                  data_cnt_nxt = data_cnt + 8'd1;
                  if (data_cnt + 8'd1 == ll)
                    state_nxt = ST_CSUM;
                end
                default: begin
                  state_nxt = ST_CHECK;
                end
              endcase
            end
          end
        end

        // Zero-length data records have no last word, so the range check
        // only applies when there is at least one word to write.
        ST_CHECK: begin
          if (sum != 8'd0) begin
            state_nxt    = ST_ERR;
            err_nxt      = 1'b1;
            err_code_nxt = ERR_CSUM;
          end else if (tt == TT_DATA && addr[0]) begin
            state_nxt    = ST_ERR;
            err_nxt      = 1'b1;
            err_code_nxt = ERR_ALIGN;
          end else if (tt == TT_DATA && ll != 8'd0 && (last_word >> ADDR_W) != 17'd0) begin
            state_nxt    = ST_ERR;
            err_nxt      = 1'b1;
            err_code_nxt = ERR_RANGE;
          end else if (tt == TT_DATA && ll != 8'd0) begin
            state_nxt   = ST_WRITE;
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = word_addr;
            wr_data_nxt = {hi_byte[5:0], lo_byte};
            wr_idx_nxt  = wr_idx + 8'd1;
          end else if (tt == TT_EOF) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end

        // Word 0 went out on the CHECK->WRITE edge; wr_idx is the next word.
        ST_WRITE: begin
          if (wr_idx == {1'b0, ll[7:1]}) begin
            state_nxt = ST_IDLE;
          end else begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = word_addr;
            wr_data_nxt = {hi_byte[5:0], lo_byte};
            wr_idx_nxt  = wr_idx + 8'd1;
          end
        end

        ST_DONE, ST_ERR: begin
          state_nxt = state;
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers. ready/busy are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state            <= ST_IDLE;
      nib_cnt          <= 2'd0;
      nib_hi           <= 4'd0;
      ll               <= 8'd0;
      addr             <= 16'd0;
      tt               <= 8'd0;
      sum              <= 8'd0;
      data_cnt         <= 8'd0;
      wr_idx           <= 8'd0;
      bus.ch_ready_out <= 1'b1;
      bus.wr_en_out    <= 1'b0;
      bus.wr_addr_out  <= '0;
      bus.wr_data_out  <= 14'd0;
      bus.busy_out     <= 1'b0;
      bus.done_out     <= 1'b0;
      bus.err_out      <= 1'b0;
      bus.err_code_out <= ERR_NONE;
    end else begin
      state            <= state_nxt;
      nib_cnt          <= nib_cnt_nxt;
      nib_hi           <= nib_hi_nxt;
      ll               <= ll_nxt;
      addr             <= addr_nxt;
      tt               <= tt_nxt;
      sum              <= sum_nxt;
      data_cnt         <= data_cnt_nxt;
      wr_idx           <= wr_idx_nxt;
      bus.ch_ready_out <= (state_nxt <= ST_CSUM);
      bus.wr_en_out    <= wr_en_nxt;
      bus.wr_addr_out  <= wr_addr_nxt;
      bus.wr_data_out  <= wr_data_nxt;
      bus.busy_out     <= !(state_nxt == ST_IDLE || state_nxt == ST_DONE || state_nxt == ST_ERR);
      bus.done_out     <= done_nxt;
      bus.err_out      <= err_nxt;
      bus.err_code_out <= err_code_nxt;
    end
  end
endmodule

// File: tb/tb_pic16f84_hex_loader.sv
// tb_pic16f84_hex_loader
// Directed bench for the Intel HEX loader: feeds records one character at a
// time and checks handshake timing, written words and error codes.
module tb_pic16f84_hex_loader;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [13:0] q_addr[$];
  logic [13:0] q_data[$];

  always #5 clk = ~clk;

  pic16f84_hex_loader_if #(.ADDR_W(14)) bus ();

  pic16f84_hex_loader #(
    .ADDR_W  (14),
    .MAX_DATA(16)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  // Log every word the loader writes into program memory.
  always @(posedge clk) begin
    if (bus.wr_en_out === 1'b1) begin
      q_addr.push_back(bus.wr_addr_out);
      q_data.push_back(bus.wr_data_out);
    end
  end

  // Hard stop in case something wedges the sequence below.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_char(input logic [7:0] c);
    int waited = 0;
    bus.ch_in       = c;
    bus.ch_valid_in = 1'b1;
    while (bus.ch_ready_out !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: ready=%b required 1", bus.ch_ready_out);
    end
    @(posedge clk);
    @(negedge clk);
    bus.ch_valid_in = 1'b0;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i]);
  endtask

  task automatic pulse_clr();
    bus.clr_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clr_in = 1'b0;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.clr_in      = 1'b0;
    bus.ch_valid_in = 1'b0;
    bus.ch_in       = 8'h00;
    repeat (3) @(negedge clk);

    checkOutput("rst_ready",    bus.ch_ready_out, 1);
    checkOutput("rst_wr_en",    bus.wr_en_out,    0);
    checkOutput("rst_wr_addr",  bus.wr_addr_out,  0);
    checkOutput("rst_wr_data",  bus.wr_data_out,  0);
    checkOutput("rst_busy",     bus.busy_out,     0);
    checkOutput("rst_done",     bus.done_out,     0);
    checkOutput("rst_err",      bus.err_out,      0);
    checkOutput("rst_err_code", bus.err_code_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] two-word data record");
    clear_log();
    applyStimulus(":04000000FF3F01308D");
    checkOutput("s1_check_ready", bus.ch_ready_out, 0);
    checkOutput("s1_check_wr_en", bus.wr_en_out,    0);
    checkOutput("s1_check_busy",  bus.busy_out,     1);
    @(negedge clk);
    checkOutput("s1_w0_en",   bus.wr_en_out,   1);
    checkOutput("s1_w0_addr", bus.wr_addr_out, 14'h0000);
    checkOutput("s1_w0_data", bus.wr_data_out, 14'h3FFF);
    @(negedge clk);
    checkOutput("s1_w1_en",   bus.wr_en_out,   1);
    checkOutput("s1_w1_addr", bus.wr_addr_out, 14'h0001);
    checkOutput("s1_w1_data", bus.wr_data_out, 14'h3001);
    @(negedge clk);
    checkOutput("s1_end_wr_en", bus.wr_en_out,    0);
    checkOutput("s1_end_ready", bus.ch_ready_out, 1);
    checkOutput("s1_end_busy",  bus.busy_out,     0);
    checkOutput("s1_end_err",   bus.err_out,      0);
    checkOutput("s1_nwrites",   q_addr.size(),    2);

    $display("[TB] config word record");
    applyStimulus(":02400E00F23F7F");
    @(negedge clk);
    checkOutput("s2_en",   bus.wr_en_out,   1);
    checkOutput("s2_addr", bus.wr_addr_out, 14'h2007);
    checkOutput("s2_data", bus.wr_data_out, 14'h3FF2);
    @(negedge clk);
    checkOutput("s2_end_wr_en", bus.wr_en_out,    0);
    checkOutput("s2_end_ready", bus.ch_ready_out, 1);
    checkOutput("s2_end_err",   bus.err_out,      0);

    $display("[TB] bad checksum");
    clear_log();
    applyStimulus(":04000000FF3F01308E");
    checkOutput("s3_n1_err", bus.err_out, 0);
    @(negedge clk);
    checkOutput("s3_err",      bus.err_out,      1);
    checkOutput("s3_err_code", bus.err_code_out, 3);
    checkOutput("s3_ready",    bus.ch_ready_out, 0);
    checkOutput("s3_busy",     bus.busy_out,     0);
    repeat (3) @(negedge clk);
    checkOutput("s3_hold_err",   bus.err_out,      1);
    checkOutput("s3_hold_ready", bus.ch_ready_out, 0);
    checkOutput("s3_nwrites",    q_addr.size(),    0);
    pulse_clr();
    checkOutput("s3_clr_ready", bus.ch_ready_out, 1);
    checkOutput("s3_clr_err",   bus.err_out,      0);
    checkOutput("s3_clr_code",  bus.err_code_out, 0);

    $display("[TB] EOF record after CR/LF");
    clear_log();
    send_char(8'h0D);
    send_char(8'h0A);
    checkOutput("s4_crlf_busy", bus.busy_out, 0);
    applyStimulus(":00000001FF");
    checkOutput("s4_n1_done", bus.done_out, 0);
    @(negedge clk);
    checkOutput("s4_done",    bus.done_out,     1);
    checkOutput("s4_err",     bus.err_out,      0);
    checkOutput("s4_ready",   bus.ch_ready_out, 0);
    checkOutput("s4_nwrites", q_addr.size(),    0);
    pulse_clr();
    checkOutput("s4_clr_done",  bus.done_out,     0);
    checkOutput("s4_clr_ready", bus.ch_ready_out, 1);

    $display("[TB] lowercase hex digits");
    clear_log();
    applyStimulus(":04000000ff3f01308d");
    repeat (3) @(negedge clk);
    checkOutput("s5_nwrites", q_addr.size(), 2);
    checkOutput("s5_a0", q_addr[0], 14'h0000);
    checkOutput("s5_d0", q_data[0], 14'h3FFF);
    checkOutput("s5_a1", q_addr[1], 14'h0001);
    checkOutput("s5_d1", q_data[1], 14'h3001);
    checkOutput("s5_err", bus.err_out, 0);

    $display("[TB] character-detected errors");
    applyStimulus(":0G");
    checkOutput("s6_err",   bus.err_out,      1);
    checkOutput("s6_code",  bus.err_code_out, 1);
    checkOutput("s6_ready", bus.ch_ready_out, 0);
    pulse_clr();
    applyStimulus(":0:");
    checkOutput("s7_code", bus.err_code_out, 1);
    pulse_clr();
    applyStimulus(":12");
    checkOutput("s8_code", bus.err_code_out, 2);
    pulse_clr();
    applyStimulus(":10");
    checkOutput("s9_max_len_err",  bus.err_out,  0);
    checkOutput("s9_max_len_busy", bus.busy_out, 1);
    pulse_clr();
    checkOutput("s9_clr_busy",  bus.busy_out,     0);
    checkOutput("s9_clr_ready", bus.ch_ready_out, 1);
    applyStimulus(":01000100");
    checkOutput("s10_odd_len_code", bus.err_code_out, 2);
    pulse_clr();
    applyStimulus(":00000006");
    checkOutput("s12_type_code", bus.err_code_out, 4);
    pulse_clr();

    $display("[TB] checks made after the checksum");
    clear_log();
    applyStimulus(":02000100FF3FBF");
    @(negedge clk);
    checkOutput("s11_align_code", bus.err_code_out, 5);
    checkOutput("s11_nwrites",    q_addr.size(),    0);
    pulse_clr();
    applyStimulus(":047FFE0011223344D5");
    @(negedge clk);
    checkOutput("s13_range_code", bus.err_code_out, 6);
    checkOutput("s13_nwrites",    q_addr.size(),    0);
    pulse_clr();
    applyStimulus(":020000040000FA");
    @(negedge clk);
    checkOutput("s14_ela_err",     bus.err_out,      0);
    checkOutput("s14_ela_done",    bus.done_out,     0);
    checkOutput("s14_ela_ready",   bus.ch_ready_out, 1);
    checkOutput("s14_ela_nwrites", q_addr.size(),    0);

    $display("[TB] reset during write burst");
    clear_log();
    applyStimulus(":04000000FF3F01308D");
    @(negedge clk);
    checkOutput("s15_first_en", bus.wr_en_out, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("s15_rst_wr_en",   bus.wr_en_out,    0);
    checkOutput("s15_rst_ready",   bus.ch_ready_out, 1);
    checkOutput("s15_rst_addr",    bus.wr_addr_out,  0);
    checkOutput("s15_rst_data",    bus.wr_data_out,  0);
    checkOutput("s15_rst_busy",    bus.busy_out,     0);
    checkOutput("s15_rst_done",    bus.done_out,     0);
    checkOutput("s15_rst_err",     bus.err_out,      0);
    checkOutput("s15_rst_code",    bus.err_code_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("s15_nwrites", q_addr.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
